// File: rtl/tank_bullet.sv
`default_nettype none
// ============================================================================
// Module      : tank_bullet
// Description : Single-bullet projectile generator for one shooter. Launches
//               the bullet from the tank centre on a fire request, steps it
//               once per frame in the latched heading, and retires it at the
//               playfield edge or on a reported hit. While retired it parks
//               at (0,0). Also produces the bullet pixel-hit flag for the
//               pixel mux.
//               Optional feature macro: TANK_BULLET_COOLDOWN_EN
//                 defined   -> a COOLDOWN state holds off re-fire for
//                              COOLDOWN_TICKS frames after retirement.
//                 undefined -> retirement returns straight to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module tank_bullet #(
    parameter int SPEED          = 4,
    parameter int COOLDOWN_TICKS = 16,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int BULLET_SIZE    = 4,
    parameter int TANK_SIZE      = 32
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       refresh_tick,
    input  logic       fire,
    input  logic [1:0] dir,
    input  logic [9:0] x_tank,
    input  logic [9:0] y_tank,
    input  logic       hit,
    output logic [9:0] x_bullet,
    output logic [9:0] y_bullet,
    output logic       bullet_active,
    output logic       bullet_on,
    output logic       ready
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_FLY      = 2'd1;
`ifdef TANK_BULLET_COOLDOWN_EN
    localparam logic [1:0] c_ST_COOLDOWN = 2'd2;
    localparam int         c_CNT_W       = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(COOLDOWN_TICKS);
`endif

    // Edge tests are done 11 bits wide so the sums never wrap
    localparam logic [10:0] c_SPEED_11  = 11'(SPEED);
    localparam logic [10:0] c_X_LIMIT   = 11'(X_MAX - BULLET_SIZE + 1);
    localparam logic [10:0] c_Y_LIMIT   = 11'(Y_MAX - BULLET_SIZE + 1);
    localparam logic [10:0] c_SIZE_M1   = 11'(BULLET_SIZE - 1);
    localparam logic [9:0]  c_STEP      = 10'(SPEED);
    localparam logic [9:0]  c_LAUNCH_OF = 10'((TANK_SIZE - BULLET_SIZE) / 2);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [1:0] r_dir;
    logic       w_exit;
    logic       w_retire;
`ifdef TANK_BULLET_COOLDOWN_EN
    logic [c_CNT_W-1:0] r_cnt;
`endif

    // Would the next step in the latched heading leave the playfield?
    always_comb begin
        w_exit = 1'b0;
        case (r_dir)
            2'b00:   w_exit = ({1'b0, r_y} < c_SPEED_11);
            2'b01:   w_exit = (({1'b0, r_x} + c_SPEED_11) > c_X_LIMIT);
            2'b10:   w_exit = (({1'b0, r_y} + c_SPEED_11) > c_Y_LIMIT);
            default: w_exit = ({1'b0, r_x} < c_SPEED_11);
        endcase
    end

    // A hit retires immediately and takes priority over a coincident tick
    assign w_retire = hit || (refresh_tick && w_exit);

    // State register
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (fire) begin
                    w_next_state = c_ST_FLY;
                end
            end
            c_ST_FLY: begin
                if (w_retire) begin
`ifdef TANK_BULLET_COOLDOWN_EN
                    w_next_state = c_ST_COOLDOWN;
`else
                    w_next_state = c_ST_IDLE;
`endif
                end
            end
`ifdef TANK_BULLET_COOLDOWN_EN
            c_ST_COOLDOWN: begin
                // The tick that takes the counter to zero releases the shooter
                if (refresh_tick && (r_cnt <= c_CNT_W'(1))) begin
                    w_next_state = c_ST_IDLE;
                end
            end
`endif
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Position, heading and cooldown counter
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_x   <= 10'd0;
            r_y   <= 10'd0;
            r_dir <= 2'b00;
`ifdef TANK_BULLET_COOLDOWN_EN
            r_cnt <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (fire) begin
                        r_dir <= dir;
                        r_x   <= x_tank + c_LAUNCH_OF;
                        r_y   <= y_tank + c_LAUNCH_OF;
                    end
                end
                c_ST_FLY: begin
                    if (w_retire) begin
                        r_x <= 10'd0;
                        r_y <= 10'd0;
`ifdef TANK_BULLET_COOLDOWN_EN
                        r_cnt <= c_CNT_LOAD;
`endif
                    end else if (refresh_tick) begin
                        case (r_dir)
                            2'b00:   r_y <= r_y - c_STEP;
                            2'b01:   r_x <= r_x + c_STEP;
                            2'b10:   r_y <= r_y + c_STEP;
                            default: r_x <= r_x - c_STEP;
                        endcase
                    end
                end
`ifdef TANK_BULLET_COOLDOWN_EN
                c_ST_COOLDOWN: begin
                    if (refresh_tick && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
`endif
                default: begin
                    r_x <= 10'd0;
                    r_y <= 10'd0;
                end
            endcase
        end
    end

    assign x_bullet = r_x;
    assign y_bullet = r_y;

    // Status flags and pixel coverage of the bullet square
    always_comb begin
        ready         = (r_state == c_ST_IDLE);
        bullet_active = (r_state == c_ST_FLY);
        bullet_on     = bullet_active
                        && ({1'b0, x} >= {1'b0, r_x})
                        && ({1'b0, x} <= ({1'b0, r_x} + c_SIZE_M1))
                        && ({1'b0, y} >= {1'b0, r_y})
                        && ({1'b0, y} <= ({1'b0, r_y} + c_SIZE_M1));
    end

endmodule
`default_nettype wire

// File: tb/tb_tank_bullet.sv
`default_nettype none
// ============================================================================
// Module      : tb_tank_bullet
// Description : Self-checking bench for tank_bullet. A frame-level model
//               tracks where the bullet must be and the DUT is compared
//               against it on every falling edge; directed literal checks
//               pin the model at the interesting points of each scenario.
//               Honours TANK_BULLET_COOLDOWN_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_bullet;

    localparam int SPEED          = 4;
    localparam int COOLDOWN_TICKS = 16;
    localparam int X_MAX          = 639;
    localparam int Y_MAX          = 479;
    localparam int BULLET_SIZE    = 4;
    localparam int TANK_SIZE      = 32;

    localparam int M_IDLE = 0;
    localparam int M_FLY  = 1;
    localparam int M_COOL = 2;

    logic       clk_50MHz = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       refresh_tick = 1'b0;
    logic       fire = 1'b0;
    logic [1:0] dir = 2'b00;
    logic [9:0] x_tank = 10'd0;
    logic [9:0] y_tank = 10'd0;
    logic       hit = 1'b0;
    logic [9:0] x_bullet;
    logic [9:0] y_bullet;
    logic       bullet_active;
    logic       bullet_on;
    logic       ready;

    tank_bullet #(
        .SPEED(SPEED), .COOLDOWN_TICKS(COOLDOWN_TICKS), .X_MAX(X_MAX),
        .Y_MAX(Y_MAX), .BULLET_SIZE(BULLET_SIZE), .TANK_SIZE(TANK_SIZE)
    ) dut (
        .clk_50MHz(clk_50MHz), .reset(reset), .x(x), .y(y),
        .refresh_tick(refresh_tick), .fire(fire), .dir(dir),
        .x_tank(x_tank), .y_tank(y_tank), .hit(hit),
        .x_bullet(x_bullet), .y_bullet(y_bullet),
        .bullet_active(bullet_active), .bullet_on(bullet_on), .ready(ready)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model of the bullet
    // ------------------------------------------------------------------
    typedef struct {
        int st;
        int bx;
        int by;
        int hd;
        int cool;
    } model_t;

    model_t m = '{M_IDLE, 0, 0, 0, 0};
    bit     m_valid = 1'b0;

    function automatic model_t model_next(model_t c, logic rst, logic f, logic t,
                                          logic h, logic [1:0] d,
                                          logic [9:0] xt, logic [9:0] yt);
        model_t n = c;
        bit gone = 1'b0;
        if (rst) begin
            n = '{M_IDLE, 0, 0, 0, 0};
            return n;
        end
        case (c.st)
            M_IDLE: if (f) begin
                n.st = M_FLY;
                n.hd = int'(d);
                n.bx = (int'(xt) + (TANK_SIZE - BULLET_SIZE) / 2) % 1024;
                n.by = (int'(yt) + (TANK_SIZE - BULLET_SIZE) / 2) % 1024;
            end
            M_FLY: begin
                if (h) gone = 1'b1;
                else if (t) begin
                    case (c.hd)
                        0: if (c.by < SPEED) gone = 1'b1; else n.by = c.by - SPEED;
                        1: if (c.bx + SPEED > X_MAX - BULLET_SIZE + 1) gone = 1'b1; else n.bx = c.bx + SPEED;
                        2: if (c.by + SPEED > Y_MAX - BULLET_SIZE + 1) gone = 1'b1; else n.by = c.by + SPEED;
                        default: if (c.bx < SPEED) gone = 1'b1; else n.bx = c.bx - SPEED;
                    endcase
                end
                if (gone) begin
                    n.bx = 0;
                    n.by = 0;
`ifdef TANK_BULLET_COOLDOWN_EN
                    n.st   = M_COOL;
                    n.cool = COOLDOWN_TICKS;
`else
                    n.st = M_IDLE;
`endif
                end
            end
            default: if (t) begin
                n.cool = c.cool - 1;
                if (n.cool <= 0) n.st = M_IDLE;
            end
        endcase
        return n;
    endfunction

    function automatic logic model_on(model_t c, logic [9:0] px, logic [9:0] py);
        return (c.st == M_FLY)
               && int'(px) >= c.bx && int'(px) <= c.bx + BULLET_SIZE - 1
               && int'(py) >= c.by && int'(py) <= c.by + BULLET_SIZE - 1;
    endfunction

    always @(posedge clk_50MHz) begin
        m <= model_next(m, reset, fire, refresh_tick, hit, dir, x_tank, y_tank);
        if (reset) m_valid <= 1'b1;
    end

    // Every-cycle comparison against the model
    always @(negedge clk_50MHz) begin
        if (m_valid) begin
            check("m_x_bullet", 32'(x_bullet), 32'(m.bx));
            check("m_y_bullet", 32'(y_bullet), 32'(m.by));
            check("m_active", 32'(bullet_active), 32'(m.st == M_FLY));
            check("m_ready", 32'(ready), 32'(m.st == M_IDLE));
            check("m_bullet_on", 32'(bullet_on), 32'(model_on(m, x, y)));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk_50MHz);
        #1;
        x = 10'(m.bx + int'($urandom_range(0, 5)) - 1);
        y = 10'(m.by + int'($urandom_range(0, 5)) - 1);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            refresh_tick = 1'b1;
            cyc();
            refresh_tick = 1'b0;
        end
    endtask

    task automatic check_pos(input string name, input int ex, input int ey, input int act);
        check({name, "_x"}, 32'(x_bullet), 32'(ex));
        check({name, "_y"}, 32'(y_bullet), 32'(ey));
        check({name, "_active"}, 32'(bullet_active), 32'(act));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cyc();
        cyc();
        check_pos("reset", 0, 0, 0);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_on", 32'(bullet_on), 32'd0);
        reset = 1'b0;
        cyc();

        // Launch upward, then keep fire held to show it is ignored in flight
        x_tank = 10'd100; y_tank = 10'd200; dir = 2'b00; fire = 1'b1;
        cyc();
        check_pos("launch_up", 114, 214, 1);
        check("launch_ready", 32'(ready), 32'd0);
        tick_n(1);
        check_pos("step_up", 114, 210, 1);
        x = 10'd117; y = 10'd213; #1;
        check("pix_inside", 32'(bullet_on), 32'd1);
        x = 10'd118; #1;
        check("pix_outside", 32'(bullet_on), 32'd0);
        // Tank moves and turns mid-flight: no effect on this bullet
        x_tank = 10'd600; y_tank = 10'd100; dir = 2'b01;
        tick_n(52);
        check_pos("top_tick53", 114, 2, 1);
        tick_n(1);
        check_pos("top_exit", 0, 0, 0);
`ifdef TANK_BULLET_COOLDOWN_EN
        check("top_exit_ready", 32'(ready), 32'd0);
        tick_n(15);
        check("cool15_ready", 32'(ready), 32'd0);
        check_pos("cool15", 0, 0, 0);
        tick_n(1);
        check("cool16_ready", 32'(ready), 32'd1);
`else
        check("top_exit_ready", 32'(ready), 32'd1);
`endif
        // Fire still held: relaunch from the current tank position, heading right
        cyc();
        check_pos("launch_right", 614, 114, 1);
        fire = 1'b0;
        tick_n(5);
        check_pos("right_tick5", 634, 114, 1);
        tick_n(1);
        check_pos("right_exit", 0, 0, 0);
`ifdef TANK_BULLET_COOLDOWN_EN
        tick_n(16);
`endif
        check("right_ready", 32'(ready), 32'd1);

        // Hit coinciding with a tick: retire with no step
        x_tank = 10'd200; y_tank = 10'd300; dir = 2'b10; fire = 1'b1;
        cyc();
        fire = 1'b0;
        check_pos("launch_down", 214, 314, 1);
        tick_n(1);
        check_pos("step_down", 214, 318, 1);
        cyc();
        hit = 1'b1; refresh_tick = 1'b1;
        cyc();
        hit = 1'b0; refresh_tick = 1'b0;
        check_pos("hit_tick", 0, 0, 0);
`ifdef TANK_BULLET_COOLDOWN_EN
        check("hit_ready", 32'(ready), 32'd0);
        hit = 1'b1;
        tick_n(15);
        check("hit_cool15_ready", 32'(ready), 32'd0);
        tick_n(1);
        hit = 1'b0;
        check("hit_cool16_ready", 32'(ready), 32'd1);
`else
        check("hit_ready", 32'(ready), 32'd1);
`endif

        // Bottom edge
        x_tank = 10'd10; y_tank = 10'd440; dir = 2'b10; fire = 1'b1;
        cyc();
        fire = 1'b0;
        check_pos("launch_bot", 24, 454, 1);
        tick_n(5);
        check_pos("bot_tick5", 24, 474, 1);
        tick_n(1);
        check_pos("bot_exit", 0, 0, 0);
        // Reset during cooldown (or idle) lands in IDLE
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_cool_ready", 32'(ready), 32'd1);

        // Leftward flight, then reset mid-flight with every other input busy
        x_tank = 10'd50; y_tank = 10'd50; dir = 2'b11; fire = 1'b1;
        cyc();
        fire = 1'b0;
        check_pos("launch_left", 64, 64, 1);
        tick_n(2);
        check_pos("left_tick2", 56, 64, 1);
        reset = 1'b1; fire = 1'b1; hit = 1'b1; refresh_tick = 1'b1;
        cyc();
        reset = 1'b0; fire = 1'b0; hit = 1'b0; refresh_tick = 1'b0;
        x = 10'd57; y = 10'd65; #1;
        check_pos("rst_fly", 0, 0, 0);
        check("rst_fly_ready", 32'(ready), 32'd1);
        check("rst_fly_on", 32'(bullet_on), 32'd0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
